mac_unit_stripes_seq: RTL and testbench

- Parametrised, self-sequencing bit-serial (Stripes-style) dot-product MAC.
- Each beat takes one weight bit-column across VEC_LENGTH lanes together with VEC_LENGTH signed activations.
- An internal column counter replaces the external column index and MSB flag. Runtime weight precision (1..W_PREC_MAX) and signed/unsigned weight mode are selectable.
- Valid/ready handshakes on input and output; the result is shifted and saturated for the next layer. Sits between the activation/weight buffers and the output writeback, one instance per PE column.

---
 rtl/mac_unit_stripes_seq.sv | 204 ++++++++++++++++++++
 tb/tb_mac_unit_stripes_seq.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_unit_stripes_seq.sv
// mac_unit_stripes_seq
//   Self-sequencing bit-serial (Stripes-style) dot-product MAC. Each accepted
//   beat carries one weight bit-column across VEC_LENGTH lanes plus the
//   matching signed activations. An internal column counter walks the weight
//   bits LSB-first up to the runtime precision. The finished sum is offered
//   both at full precision and as a shifted, saturated result.
//
// Ports
//   clk, reset      rising-edge clock, asynchronous active-low reset
//   in_valid/ready  beat handshake (act_in, w_bit and first-beat controls)
//   act_in          VEC_LENGTH signed activations
//   w_bit           weight bit-column for the current beat
//   w_prec_m1       weight precision minus one      (first beat only)
//   w_signed        MSB column has negative weight  (first beat only)
//   load_accum      seed accumulator from accum_prev (first beat only)
//   accum_prev      signed seed value               (first beat only)
//   out_shift       arithmetic right shift of result (first beat only)
//   out_valid/ready result handshake
//   accum_out       full-precision accumulator
//   result          accum_out >>> out_shift, saturated to RESULT_WIDTH
module mac_unit_stripes_seq #(
    parameter int DATA_WIDTH   = 8,
    parameter int VEC_LENGTH   = 16,
    parameter int W_PREC_MAX   = 8,
    parameter int ACC_WIDTH    = DATA_WIDTH + 16,
    parameter int RESULT_WIDTH = 2 * DATA_WIDTH,
    localparam int PREC_W      = $clog2(W_PREC_MAX),
    localparam int SHIFT_W     = $clog2(ACC_WIDTH)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic signed [DATA_WIDTH-1:0]   act_in [VEC_LENGTH],
    input  logic        [VEC_LENGTH-1:0]   w_bit,
    input  logic        [PREC_W-1:0]       w_prec_m1,
    input  logic                           w_signed,
    input  logic                           load_accum,
    input  logic signed [ACC_WIDTH-1:0]    accum_prev,
    input  logic        [SHIFT_W-1:0]      out_shift,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [ACC_WIDTH-1:0]    accum_out,
    output logic signed [RESULT_WIDTH-1:0] result
);

    localparam int LOG_VEC = $clog2(VEC_LENGTH);
    localparam int SUM_W   = DATA_WIDTH + LOG_VEC;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic        [PREC_W-1:0]    col;
    logic        [PREC_W-1:0]    prec_q;
    logic                        signed_q;
    logic signed [ACC_WIDTH-1:0] seed_q;
    logic        [SHIFT_W-1:0]   shift_q;

    logic signed [ACC_WIDTH-1:0] s1_q;
    logic                        s1_valid_q;
    logic                        s1_first_q;
    logic signed [ACC_WIDTH-1:0] acc_q;

    logic                        accept;
    logic                        first_beat;
    logic        [PREC_W-1:0]    prec_eff;
    logic                        signed_eff;
    logic                        last_col;

    logic signed [SUM_W-1:0]     lane_sum;
    logic signed [SUM_W:0]       col_ext;
    logic signed [ACC_WIDTH-1:0] col_term;
    logic signed [ACC_WIDTH-1:0] acc_nxt;
    logic signed [ACC_WIDTH-1:0] shifted;
    logic [ACC_WIDTH-RESULT_WIDTH:0] upper;
    logic signed [RESULT_WIDTH-1:0] sat_val;

    assign accept     = in_valid & in_ready;
    assign first_beat = (state == S_IDLE);

    // The first beat must use the live control inputs, since the latched
    // copies only become valid on the edge that accepts it.
    assign prec_eff   = first_beat ? w_prec_m1 : prec_q;
    assign signed_eff = first_beat ? w_signed  : signed_q;
    assign last_col   = (col == prec_eff);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (accept) state_nxt = last_col ? S_DRAIN : S_ACCUM;
            S_ACCUM: if (accept && last_col) state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = S_DONE;
            S_DONE:  if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            S_IDLE, S_ACCUM: in_ready  = 1'b1;
            S_DONE:          out_valid = 1'b1;
            default: ;
        endcase
    end

    // ---------------- Column counter and first-beat latches ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col      <= '0;
            prec_q   <= '0;
            signed_q <= 1'b0;
            seed_q   <= '0;
            shift_q  <= '0;
        end else if (accept) begin
            col <= last_col ? '0 : col + 1'b1;
            if (first_beat) begin
                prec_q   <= w_prec_m1;
                signed_q <= w_signed;
                seed_q   <= load_accum ? accum_prev : '0;
                shift_q  <= out_shift;
            end
        end
    end

    // ---------------- Column term: masked lane sum, weighted by 2^col ----------------
    always_comb begin
        lane_sum = '0;
        for (int unsigned j = 0; j < VEC_LENGTH; j++) begin
            if (w_bit[j]) begin
                lane_sum = lane_sum + {{LOG_VEC{act_in[j][DATA_WIDTH-1]}}, act_in[j]};
            end
        end
        // One extra bit so that negating the most negative sum cannot overflow.
        col_ext = {lane_sum[SUM_W-1], lane_sum};
        if (last_col && signed_eff) begin
            col_ext = -col_ext;
        end
        col_term = {{(ACC_WIDTH-SUM_W-1){col_ext[SUM_W]}}, col_ext};
        col_term = col_term << col;
    end

    // Stage 2: the first column restarts from the seed instead of the old sum.
    assign acc_nxt = s1_q + (s1_first_q ? seed_q : acc_q);

    // ---------------- Output shift and saturation ----------------
    always_comb begin
        shifted = acc_nxt >>> shift_q;
        upper   = shifted[ACC_WIDTH-1:RESULT_WIDTH-1];
        if ((upper == '0) || (upper == '1)) begin
            sat_val = shifted[RESULT_WIDTH-1:0];
        end else if (shifted[ACC_WIDTH-1]) begin
            sat_val = {1'b1, {(RESULT_WIDTH-1){1'b0}}};
        end else begin
            sat_val = {1'b0, {(RESULT_WIDTH-1){1'b1}}};
        end
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q       <= '0;
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            acc_q      <= '0;
            accum_out  <= '0;
            result     <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_q       <= col_term;
                s1_first_q <= first_beat;
            end
            if (s1_valid_q) begin
                acc_q <= acc_nxt;
            end
            // DRAIN always carries the final column in stage 1, so the
            // outputs are taken from the stage-2 sum directly on DONE entry.
            if (state == S_DRAIN) begin
                accum_out <= acc_nxt;
                result    <= sat_val;
            end
        end
    end

endmodule

// File: tb/tb_mac_unit_stripes_seq.sv
module tb_mac_unit_stripes_seq;

    localparam int DW = 8;
    localparam int VL = 16;
    localparam int WP = 8;
    localparam int AW = DW + 16;
    localparam int RW = 2 * DW;
    localparam int PW = $clog2(WP);
    localparam int SW = $clog2(AW);

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic signed [DW-1:0]   act_in [VL];
    logic        [VL-1:0]   w_bit = '0;
    logic        [PW-1:0]   w_prec_m1 = '0;
    logic                   w_signed = 1'b0;
    logic                   load_accum = 1'b0;
    logic signed [AW-1:0]   accum_prev = '0;
    logic        [SW-1:0]   out_shift = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic signed [AW-1:0]   accum_out;
    logic signed [RW-1:0]   result;

    always #5 clk = ~clk;

    mac_unit_stripes_seq #(
        .DATA_WIDTH  (DW),
        .VEC_LENGTH  (VL),
        .W_PREC_MAX  (WP),
        .ACC_WIDTH   (AW),
        .RESULT_WIDTH(RW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .act_in    (act_in),
        .w_bit     (w_bit),
        .w_prec_m1 (w_prec_m1),
        .w_signed  (w_signed),
        .load_accum(load_accum),
        .accum_prev(accum_prev),
        .out_shift (out_shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .accum_out (accum_out),
        .result    (result)
    );

    typedef struct {
        int     act_base, act_step, w_base, w_step;
        int     prec_m1, sgn, load;
        longint prev;
        int     shift, stall_after, stall_len;
        longint exp_acc, exp_res;
    } vec_t;

    typedef struct {
        longint acc;
        longint res;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic signed [DW-1:0] cur_act [VL];
    int                   cur_w   [VL];
    int                   cur_prec, cur_shift, cur_stall_after, cur_stall_len;
    logic                 cur_sgn, cur_load;
    longint               cur_prev;

    vec_t tab [13];

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d required %0d", name, got, exp);
    endtask

    function automatic vec_t mk(int ab, int as, int wb, int ws, int p, int s, int l,
                                longint pv, int sh, int sa, int sl, longint ea, longint er);
        vec_t v;
        v = '{ab, as, wb, ws, p, s, l, pv, sh, sa, sl, ea, er};
        return v;
    endfunction

    task automatic load_vec(input vec_t v);
        for (int j = 0; j < VL; j++) begin
            cur_act[j] = DW'(v.act_base + j * v.act_step);
            cur_w[j]   = (v.w_base + j * v.w_step) & ((1 << (v.prec_m1 + 1)) - 1);
        end
        cur_prec        = v.prec_m1;
        cur_sgn         = v.sgn[0];
        cur_load        = v.load[0];
        cur_prev        = v.prev;
        cur_shift       = v.shift;
        cur_stall_after = v.stall_after;
        cur_stall_len   = v.stall_len;
    endtask

    // Independent reference: per-lane multiply by the full weight value.
    function automatic void model(output longint acc, output longint res);
        longint s, wv, lim;
        s = 0;
        for (int j = 0; j < VL; j++) begin
            wv = longint'(cur_w[j]);
            if (cur_sgn && cur_w[j][cur_prec]) wv = wv - (longint'(1) << (cur_prec + 1));
            s = s + longint'(cur_act[j]) * wv;
        end
        if (cur_load) s = s + cur_prev;
        acc = s & ((longint'(1) << AW) - 1);
        if (acc >= (longint'(1) << (AW - 1))) acc = acc - (longint'(1) << AW);
        res = acc >>> cur_shift;
        lim = longint'(1) << (RW - 1);
        if (res > lim - 1) res = lim - 1;
        if (res < -lim) res = -lim;
    endfunction

    // Non-first beats carry scrambled control inputs, which must be ignored.
    task automatic set_beat(input int k);
        for (int j = 0; j < VL; j++) begin
            act_in[j] = cur_act[j];
            w_bit[j]  = cur_w[j][k];
        end
        if (k == 0) begin
            w_prec_m1  = PW'(cur_prec);
            w_signed   = cur_sgn;
            load_accum = cur_load;
            accum_prev = AW'(cur_prev);
            out_shift  = SW'(cur_shift);
        end else begin
            w_prec_m1  = ~PW'(cur_prec);
            w_signed   = ~cur_sgn;
            load_accum = ~cur_load;
            accum_prev = AW'($urandom);
            out_shift  = SW'($urandom);
        end
    endtask

    task automatic wait_accept();
        int g;
        g = 0;
        while (!in_ready && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 50) begin
            n_checks++;
            $display("FAIL in_ready_timeout: got in_ready=0 required 1 within 50 cycles");
        end
        @(posedge clk); #1;
    endtask

    task automatic drive_txn(input longint ea, input longint er);
        sb.push_back('{ea, er});
        for (int k = 0; k <= cur_prec; k++) begin
            if (k > 0 && k == cur_stall_after) begin
                in_valid = 1'b0;
                repeat (cur_stall_len) begin @(posedge clk); #1; end
            end
            set_beat(k);
            in_valid = 1'b1;
            wait_accept();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 200) begin
            n_checks++;
            $display("FAIL drain_timeout: got %0d pending results required 0", sb.size());
        end
        @(posedge clk); #1;
    endtask

    // Scoreboard consumer: compare on every output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output: got out_valid=1 required no pending result");
            end else begin
                e = sb.pop_front();
                check("accum_out", accum_out, e.acc);
                check("result", result, e.res);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running required completion");
        $fatal(1);
    end

    initial begin
        longint ea, er;
        for (int j = 0; j < VL; j++) act_in[j] = '0;

        //            ab    as  wb   ws p  s  l  prev     sh sa sl  exp_acc  exp_res
        tab[0]  = mk(  1,   0,   3, 0, 1, 0, 0,       0, 0, 0, 0,      48,     48);
        tab[1]  = mk(  2,   0, 255, 0, 7, 1, 0,       0, 0, 0, 0,     -32,    -32);
        tab[2]  = mk(-128,  0, 128, 0, 7, 1, 0,       0, 0, 0, 0,  262144,  32767);
        tab[3]  = mk(-128,  0, 128, 0, 7, 1, 0,       0, 4, 0, 0,  262144,  16384);
        tab[4]  = mk(  5,   0,   0, 0, 3, 0, 1,    1000, 0, 0, 0,    1000,   1000);
        tab[5]  = mk(  1,   0,   1, 0, 3, 0, 0,       0, 0, 0, 0,      16,     16);
        tab[6]  = mk(  3,   0,   1, 0, 0, 1, 0,       0, 0, 0, 0,     -48,    -48);
        tab[7]  = mk( -5,   0,   1, 0, 0, 0, 0,       0, 0, 0, 0,     -80,    -80);
        tab[8]  = mk(-128,  0, 255, 0, 7, 0, 0,       0, 0, 0, 0, -522240, -32768);
        tab[9]  = mk(-128,  0, 255, 0, 7, 0, 0,       0, 5, 0, 0, -522240, -16320);
        tab[10] = mk( -8,   1,   0, 1, 3, 0, 0,       0, 0, 0, 0,     280,    280);
        tab[11] = mk( 10,   0,  13, 0, 3, 1, 1, -100000, 3, 0, 0, -100480, -12560);
        tab[12] = mk(  2,   0, 255, 0, 7, 1, 0,       0, 0, 3, 3,     -32,    -32);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_accum_out", accum_out, 0);
        check("rst_result", result, 0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1);

        // Table-driven vectors, back to back
        for (int i = 0; i < 13; i++) begin
            load_vec(tab[i]);
            drive_txn(tab[i].exp_acc, tab[i].exp_res);
        end
        wait_drain();

        // Latency and state sequence for a 2-bit transaction
        load_vec(tab[0]);
        sb.push_back('{48, 48});
        set_beat(0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        check("lat_accum_in_ready", in_ready, 1);
        check("lat_accum_out_valid", out_valid, 0);
        set_beat(1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("lat_drain_in_ready", in_ready, 0);
        check("lat_drain_out_valid", out_valid, 0);
        @(posedge clk); #1;
        check("lat_done_out_valid", out_valid, 1);
        check("lat_done_in_ready", in_ready, 0);
        @(posedge clk); #1;
        check("lat_idle_out_valid", out_valid, 0);
        check("lat_idle_in_ready", in_ready, 1);

        // Output back-pressure: DONE holds steady while out_ready is low
        out_ready = 1'b0;
        load_vec(tab[2]);
        drive_txn(tab[2].exp_acc, tab[2].exp_res);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            check("hold_out_valid", out_valid, 1);
            check("hold_accum_out", accum_out, 262144);
            check("hold_result", result, 32767);
            check("hold_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_out_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);

        // Reset after the 3rd of 8 beats
        load_vec(tab[1]);
        for (int k = 0; k < 3; k++) begin
            set_beat(k);
            in_valid = 1'b1;
            wait_accept();
        end
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_accum_out", accum_out, 0);
        check("midrst_result", result, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_in_ready", in_ready, 1);
        load_vec(tab[0]);
        drive_txn(48, 48);
        wait_drain();

        // Random transactions against the reference model
        for (int i = 0; i < 8; i++) begin
            cur_prec = int'($urandom_range(0, WP - 1));
            for (int j = 0; j < VL; j++) begin
                cur_act[j] = DW'($urandom);
                cur_w[j]   = int'($urandom) & ((1 << (cur_prec + 1)) - 1);
            end
            cur_sgn         = 1'($urandom);
            cur_load        = 1'($urandom);
            cur_prev        = longint'($urandom_range(0, 2097151)) - 1048576;
            cur_shift       = int'($urandom_range(0, 12));
            cur_stall_after = 0;
            cur_stall_len   = 0;
            model(ea, er);
            drive_txn(ea, er);
        end
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
